serial_subtractor: RTL and testbench

//  Bit-serial unsigned subtractor: computes oDiff = iA - iB (mod 2^WIDTH) and the final borrow.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request in, result and status out.
// The master drives iStart/iA/iB; the slave (the subtractor) returns oDiff/oBout/oBusy/oDone.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             iStart;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic [WIDTH-1:0] oDiff;
   logic             oBout;
   logic             oBusy;
   logic             oDone;

   modport master (
      output iStart, iA, iB,
      input  oDiff, oBout, oBusy, oDone
   );

   modport slave (
      input  iStart, iA, iB,
      output oDiff, oBout, oBusy, oDone
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (A - B mod 2^WIDTH plus final borrow), one bit per clock, LSB first.
// oDone pulses WIDTH edges after the accepting edge; no backpressure, iStart is ignored while busy.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 iClk,
   input  logic                 iRst,
   serial_subtractor_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_br;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_a;
   logic             w_b;
   logic             w_d;
   logic             w_br_next;
   logic [WIDTH-1:0] w_res_next;

   // Full-subtractor cell on the current LSBs.
   assign w_a        = r_a[0];
   assign w_b        = r_b[0];
   assign w_d        = w_a ^ w_b ^ r_br;
   assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
   assign w_accept = (r_state != S_BUSY) && bus.iStart;
   assign w_last   = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.iStart) w_next = S_BUSY;
         S_BUSY:  if (w_last)     w_next = S_DONE;
         S_DONE:  w_next = bus.iStart ? S_BUSY : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_a   <= bus.iA;
         r_b   <= bus.iB;
         r_br  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == S_BUSY) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_br  <= w_br_next;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
         end
      end
   end

   assign bus.oDiff = r_diff;
   assign bus.oBout = r_bout;
   assign bus.oBusy = (r_state == S_BUSY);
   assign bus.oDone = (r_state == S_DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor at WIDTH=8.
module tb_serial_subtractor;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_diff"}, 32'(bus.oDiff), 32'h0);
      check({tag, "_bout"}, 32'(bus.oBout), 32'h0);
      check({tag, "_busy"}, 32'(bus.oBusy), 32'h0);
      check({tag, "_done"}, 32'(bus.oDone), 32'h0);
   endtask

   // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.iStart = 1'b1;
      bus.iA     = a;
      bus.iB     = b;
      @(posedge clk);
      #1;
      bus.iStart = 1'b0;
      bus.iA     = ~a;
      bus.iB     = ~b;
   endtask

   // Waits (bounded) for oDone and checks timing, busy length, held result and the new result.
   task automatic wait_done(input string tag, input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                            input logic [WIDTH-1:0] prev_d, input bit inject, input bit verbose);
      int n;
      int busy_cycles;
      int hold_bad;
      n = 0;
      busy_cycles = 0;
      hold_bad = 0;
      while (!bus.oDone && n < 40) begin
         if (bus.oBusy) busy_cycles++;
         if (bus.oDiff !== prev_d) hold_bad++;
         if (inject && n == 2) begin
            bus.iStart = 1'b1;
            bus.iA     = 8'h10;
            bus.iB     = 8'h01;
         end
         if (inject && n == 3) bus.iStart = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_done"}, 32'(bus.oDone), 32'h1);
      check({tag, "_diff"}, 32'(bus.oDiff), 32'(exp_d));
      check({tag, "_bout"}, 32'(bus.oBout), 32'(exp_bo));
      if (verbose) begin
         check({tag, "_edges"}, 32'(n), 32'(WIDTH));
         check({tag, "_busycyc"}, 32'(busy_cycles), 32'(WIDTH));
         check({tag, "_hold"}, 32'(hold_bad), 32'h0);
         check({tag, "_busy_in_done"}, 32'(bus.oBusy), 32'h0);
      end
   endtask

   initial begin
      logic [WIDTH:0]   ref_v;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [WIDTH-1:0] prev;
      int               extra_done;

      checks = 0;
      errors = 0;
      rst        = 1'b1;
      bus.iStart = 1'b0;
      bus.iA     = '0;
      bus.iB     = '0;
      #12;
      check_idle_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // T2: basic 5 - 3
      start_op(8'h05, 8'h03);
      check("t2_busy_after_accept", 32'(bus.oBusy), 32'h1);
      wait_done("t2", 8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("t2_done_one_cycle", 32'(bus.oDone), 32'h0);
      check("t2_diff_held_idle", 32'(bus.oDiff), 32'h02);

      // T1: asynchronous reset in the middle of a cycle aborts a running operation
      start_op(8'h40, 8'h11);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_idle_zero("t1_async");
      #4;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_idle_zero("t1_after");

      // T3: borrow cases
      start_op(8'h03, 8'h05);
      wait_done("t3a", 8'hFE, 1'b1, 8'h00, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      start_op(8'h00, 8'h01);
      wait_done("t3b", 8'hFF, 1'b1, 8'hFE, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // T4: equal operands and MSB-only minuend
      start_op(8'hFF, 8'hFF);
      wait_done("t4a", 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      start_op(8'h80, 8'h00);
      wait_done("t4b", 8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // T5: start during BUSY ignored; start held in DONE accepted back-to-back
      start_op(8'h05, 8'h03);
      wait_done("t5a", 8'h02, 1'b0, 8'h80, 1'b1, 1'b1);
      start_op(8'h10, 8'h01);
      check("t5_b2b_busy", 32'(bus.oBusy), 32'h1);
      wait_done("t5b", 8'h0F, 1'b0, 8'h02, 1'b0, 1'b1);
      @(posedge clk);
      #1;

      // T6: reset during the 4th busy cycle, no done afterwards, then a fresh op
      start_op(8'h07, 8'h01);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      check("t6_busy_before_rst", 32'(bus.oBusy), 32'h1);
      rst = 1'b1;
      #1;
      check_idle_zero("t6_rst");
      #4;
      rst = 1'b0;
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.oDone || bus.oBusy) extra_done++;
      end
      check("t6_no_done", 32'(extra_done), 32'h0);
      start_op(8'h0A, 8'h04);
      wait_done("t6", 8'h06, 1'b0, 8'h00, 1'b0, 1'b1);

      // Random sweep, issued back-to-back from the DONE cycle
      prev = 8'h06;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 50 == 0) rb = ra;
         ref_v = {1'b0, ra} - {1'b0, rb};
         start_op(ra, rb);
         wait_done("rand", ref_v[WIDTH-1:0], ref_v[WIDTH], prev, 1'b0, 1'b0);
         prev = ref_v[WIDTH-1:0];
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
